ppg_beat_detect: RTL and testbench

//  Consumer of the filtered PPG stream: takes signed, zero-centred AC samples plus a
//  one-cycle valid strobe from the PPG filter, detects systolic peaks, and measures the

---
 rtl/ppg_beat_detect_if.sv | 24 ++
 rtl/ppg_beat_detect.sv | 153 +++++++++++++++
 tb/tb_ppg_beat_detect.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/ppg_beat_detect_if.sv
// Sample stream into the beat detector and the beat/IBI/BPM reporting outputs.
// master drives samples and observes results; slave is the detector itself.
interface ppg_beat_detect_if #(
  parameter int DATA_WIDTH = 18,
  parameter int IBI_W      = 16
);
  logic                         i_data_valid;
  logic signed [DATA_WIDTH-1:0] i_data;
  logic                         o_beat;
  logic [IBI_W-1:0]             o_ibi;
  logic [7:0]                   o_bpm;
  logic                         o_bpm_valid;
  logic                         o_busy;

  modport master (
    output i_data_valid, i_data,
    input  o_beat, o_ibi, o_bpm, o_bpm_valid, o_busy
  );

  modport slave (
    input  i_data_valid, i_data,
    output o_beat, o_ibi, o_bpm, o_bpm_valid, o_busy
  );
endinterface

// File: rtl/ppg_beat_detect.sv
// Systolic peak detector on a zero-centred PPG stream: measures inter-beat interval
// in samples and converts it to BPM with a 24-step restoring divider.
module ppg_beat_detect #(
  parameter int DATA_WIDTH  = 18,
  parameter int SAMPLE_RATE = 100,
  parameter int THRESH      = 64,
  parameter int REFRACT     = 30,
  parameter int TIMEOUT     = 300,
  parameter int IBI_W       = 16
) (
  input logic            clk,
  input logic            rst_n,
  ppg_beat_detect_if.slave bus
);

  typedef enum logic {S_BELOW, S_ABOVE} state_t;

  localparam int                          DIV_W    = 24;
  localparam logic signed [DATA_WIDTH-1:0] THR     = DATA_WIDTH'(THRESH);
  localparam logic [IBI_W-1:0]            REF_LIM  = IBI_W'(REFRACT);
  localparam logic [IBI_W-1:0]            TO_LIM   = IBI_W'(TIMEOUT);
  localparam logic [DIV_W-1:0]            DIVIDEND = DIV_W'(60 * SAMPLE_RATE);
  localparam logic [4:0]                  DIV_LAST = 5'(DIV_W);

  function automatic logic [7:0] sat_bpm(input logic [DIV_W-1:0] q);
    return (q > DIV_W'(255)) ? 8'd255 : q[7:0];
  endfunction

  logic signed [DATA_WIDTH-1:0] sample;
  logic                         is_neg;

  state_t                       state, state_nx;
  logic signed [DATA_WIDTH-1:0] max_val, max_nx;
  logic [IBI_W-1:0]             cand_ibi, cand_nx;
  logic [IBI_W-1:0]             since_peak, since_nx, sp_inc;
  logic                         have_prev, prev_nx;
  logic                         beat_nx;

  logic                         beat_r;
  logic [IBI_W-1:0]             ibi_r;
  logic [7:0]                   bpm_r;
  logic                         bpm_vld_r;
  logic                         busy;
  logic [4:0]                   cnt;
  logic [IBI_W-1:0]             rem, dvs, rem_nx;
  logic [DIV_W-1:0]             quo;
  logic [IBI_W:0]               trial;
  logic                         trial_ge;

  assign sample = bus.i_data;
  assign is_neg = sample[DATA_WIDTH-1];

  always_comb begin
    sp_inc   = (since_peak >= TO_LIM) ? TO_LIM : since_peak + IBI_W'(1);
    state_nx = state;
    max_nx   = max_val;
    cand_nx  = cand_ibi;
    since_nx = since_peak;
    prev_nx  = have_prev;
    beat_nx  = 1'b0;
    if (bus.i_data_valid) begin
      since_nx = sp_inc;
      if (sp_inc == TO_LIM) prev_nx = 1'b0;
      case (state)
        S_BELOW: begin
          if (sample > THR) begin
            state_nx = S_ABOVE;
            max_nx   = sample;
            cand_nx  = sp_inc;
          end
        end
        S_ABOVE: begin
          if (is_neg) begin
            state_nx = S_BELOW;
            // Too-short candidates leave the interval count running from the last real peak.
            if (cand_ibi >= REF_LIM) begin
              since_nx = sp_inc - cand_ibi;
              beat_nx  = prev_nx && (cand_ibi < TO_LIM);
              prev_nx  = 1'b1;
            end
          end else if (sample > max_val) begin
            max_nx  = sample;
            cand_nx = sp_inc;
          end
        end
        default: state_nx = S_BELOW;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_BELOW;
      max_val    <= '0;
      cand_ibi   <= '0;
      since_peak <= '0;
      have_prev  <= 1'b0;
      beat_r     <= 1'b0;
      ibi_r      <= '0;
    end else begin
      state      <= state_nx;
      max_val    <= max_nx;
      cand_ibi   <= cand_nx;
      since_peak <= since_nx;
      have_prev  <= prev_nx;
      beat_r     <= beat_nx;
      if (beat_nx) ibi_r <= cand_ibi;
    end
  end

  // Restoring division: dividend bits shift out of quo's MSB while quotient bits shift in.
  assign trial    = {rem, quo[DIV_W-1]};
  assign trial_ge = (trial >= {1'b0, dvs});
  assign rem_nx   = trial_ge ? (trial[IBI_W-1:0] - dvs) : trial[IBI_W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy      <= 1'b0;
      cnt       <= '0;
      rem       <= '0;
      quo       <= '0;
      dvs       <= '0;
      bpm_r     <= '0;
      bpm_vld_r <= 1'b0;
    end else begin
      bpm_vld_r <= 1'b0;
      if (beat_nx) begin
        busy <= 1'b1;
        cnt  <= '0;
        rem  <= '0;
        quo  <= DIVIDEND;
        dvs  <= cand_ibi;
      end else if (busy) begin
        if (cnt == DIV_LAST) begin
          bpm_r     <= sat_bpm(quo);
          bpm_vld_r <= 1'b1;
          busy      <= 1'b0;
        end else begin
          rem <= rem_nx;
          quo <= {quo[DIV_W-2:0], trial_ge};
          cnt <= cnt + 5'd1;
        end
      end
    end
  end

  assign bus.o_beat      = beat_r;
  assign bus.o_ibi       = ibi_r;
  assign bus.o_bpm       = bpm_r;
  assign bus.o_bpm_valid = bpm_vld_r;
  assign bus.o_busy      = busy;

endmodule

// File: tb/tb_ppg_beat_detect.sv
// Directed bench for ppg_beat_detect: one instance at REFRACT=30 for the main scenarios,
// a second at REFRACT=20 for BPM saturation and divider restart.
module tb_ppg_beat_detect;
  localparam int DW = 18;
  localparam int IW = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic sel   = 1'b0;
  always #5 clk = ~clk;

  ppg_beat_detect_if #(.DATA_WIDTH(DW), .IBI_W(IW)) bus_a ();
  ppg_beat_detect_if #(.DATA_WIDTH(DW), .IBI_W(IW)) bus_b ();

  ppg_beat_detect #(.DATA_WIDTH(DW), .SAMPLE_RATE(100), .THRESH(64), .REFRACT(30),
                    .TIMEOUT(300), .IBI_W(IW)) u_dut (.clk(clk), .rst_n(rst_n), .bus(bus_a));
  ppg_beat_detect #(.DATA_WIDTH(DW), .SAMPLE_RATE(100), .THRESH(64), .REFRACT(20),
                    .TIMEOUT(300), .IBI_W(IW)) u_dut20 (.clk(clk), .rst_n(rst_n), .bus(bus_b));

  int checks = 0;
  int errors = 0;

  // Pulse bookkeeping: number of o_bpm_valid pulses and clocks from the latest o_beat.
  int pulses_a = 0, delay_a = 0, since_a = 0;
  int pulses_b = 0, delay_b = 0, since_b = 0;
  always @(negedge clk) begin
    if (bus_a.o_bpm_valid) begin
      pulses_a <= pulses_a + 1;
      delay_a  <= since_a + 1;
    end
    since_a <= bus_a.o_beat ? 0 : since_a + 1;
    if (bus_b.o_bpm_valid) begin
      pulses_b <= pulses_b + 1;
      delay_b  <= since_b + 1;
    end
    since_b <= bus_b.o_beat ? 0 : since_b + 1;
  end

  logic          obs_beat, obs_bvld, obs_busy;
  logic [IW-1:0] obs_ibi;
  logic [7:0]    obs_bpm;
  assign obs_beat = sel ? bus_b.o_beat      : bus_a.o_beat;
  assign obs_bvld = sel ? bus_b.o_bpm_valid : bus_a.o_bpm_valid;
  assign obs_busy = sel ? bus_b.o_busy      : bus_a.o_busy;
  assign obs_ibi  = sel ? bus_b.o_ibi       : bus_a.o_ibi;
  assign obs_bpm  = sel ? bus_b.o_bpm       : bus_a.o_bpm;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic smp(input int v);
    if (sel) begin
      bus_b.i_data_valid = 1'b1;
      bus_b.i_data       = DW'(v);
      bus_a.i_data_valid = 1'b0;
    end else begin
      bus_a.i_data_valid = 1'b1;
      bus_a.i_data       = DW'(v);
      bus_b.i_data_valid = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    bus_a.i_data_valid = 1'b0;
    bus_b.i_data_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic fill(input int n);
    repeat (n) smp(-20);
  endtask

  // Maximum on the 2nd sample; the 4th (negative) sample declares the peak.
  task automatic peak(input int a);
    smp(a / 2);
    smp(a);
    smp(a / 2);
    smp(-50);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_beat"}, 32'(obs_beat), 0);
    chk({tag, "_ibi"},  32'(obs_ibi),  0);
    chk({tag, "_bpm"},  32'(obs_bpm),  0);
    chk({tag, "_bvld"}, 32'(obs_bvld), 0);
    chk({tag, "_busy"}, 32'(obs_busy), 0);
  endtask

  initial begin
    bus_a.i_data_valid = 1'b0;
    bus_a.i_data       = '0;
    bus_b.i_data_valid = 1'b0;
    bus_b.i_data       = '0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset");
    rst_n = 1'b1;

    // First peak only establishes the reference point.
    fill(40);
    peak(500);
    chk("first_silent", 32'(obs_beat), 0);
    fill(71);
    peak(500);
    chk("beat1", 32'(obs_beat), 1);
    chk("beat1_ibi", 32'(obs_ibi), 75);
    chk("beat1_busy", 32'(obs_busy), 1);
    smp(-20);
    chk("beat1_onecycle", 32'(obs_beat), 0);
    fill(70);
    chk("beat1_bpm", 32'(obs_bpm), 80);
    chk("beat1_pulses", 32'(pulses_a), 1);
    chk("beat1_delay", 32'(delay_a), 25);
    chk("beat1_idle", 32'(obs_busy), 0);
    peak(500);
    chk("beat2", 32'(obs_beat), 1);

    // Spurious peak 20 samples after a real one is rejected.
    fill(16);
    peak(400);
    chk("spurious_beat", 32'(obs_beat), 0);
    chk("spurious_nopulse_yet", 32'(pulses_a), 1);
    fill(51);
    chk("beat2_pulses", 32'(pulses_a), 2);
    peak(500);
    chk("after_spur_beat", 32'(obs_beat), 1);
    chk("after_spur_ibi", 32'(obs_ibi), 75);

    // Amplitude 64 never arms; 65 does.
    fill(67);
    peak(64);
    chk("amp64_beat", 32'(obs_beat), 0);
    peak(65);
    chk("amp65_beat", 32'(obs_beat), 1);
    chk("amp65_ibi", 32'(obs_ibi), 75);

    // Long gap: the count saturates, so the post-gap peak becomes the new reference
    // with since_peak restarting from its declaring sample.
    fill(346);
    peak(500);
    chk("gap_beat", 32'(obs_beat), 0);
    chk("gap_ibi_held", 32'(obs_ibi), 75);
    fill(58);
    peak(500);
    chk("ibi60_beat", 32'(obs_beat), 1);
    chk("ibi60_ibi", 32'(obs_ibi), 60);

    // IBI of 100 with idle clocks mixed into the stream.
    fill(48);
    idle(20);
    fill(48);
    chk("ibi60_bpm", 32'(obs_bpm), 100);
    chk("ibi60_pulses", 32'(pulses_a), 5);
    peak(500);
    chk("ibi100_beat", 32'(obs_beat), 1);
    chk("ibi100_ibi", 32'(obs_ibi), 100);
    fill(30);
    chk("ibi100_bpm", 32'(obs_bpm), 60);
    chk("ibi100_delay", 32'(delay_a), 25);

    // Reset 10 clocks after a beat aborts the divide.
    fill(41);
    peak(500);
    chk("prerst_beat", 32'(obs_beat), 1);
    fill(10);
    rst_n = 1'b0;
    #1;
    chk_zero("midrst");
    idle(3);
    rst_n = 1'b1;
    fill(40);
    chk("rst_nopulse", 32'(pulses_a), 6);
    chk("rst_bpm", 32'(obs_bpm), 0);
    peak(500);
    chk("rst_first_silent", 32'(obs_beat), 0);
    fill(71);
    peak(500);
    chk("rst_recover_beat", 32'(obs_beat), 1);
    chk("rst_recover_ibi", 32'(obs_ibi), 75);

    // REFRACT=20 instance: IBI 20 saturates BPM, back-to-back beats restart the divider.
    sel = 1'b1;
    fill(40);
    peak(500);
    chk("r20_first_silent", 32'(obs_beat), 0);
    fill(16);
    peak(500);
    chk("r20_beat1", 32'(obs_beat), 1);
    chk("r20_ibi1", 32'(obs_ibi), 20);
    fill(16);
    peak(500);
    chk("r20_beat2", 32'(obs_beat), 1);
    chk("r20_restart_nopulse", 32'(pulses_b), 0);
    fill(30);
    chk("r20_pulses", 32'(pulses_b), 1);
    chk("r20_delay", 32'(delay_b), 25);
    chk("r20_bpm_sat", 32'(obs_bpm), 255);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
